// File: rtl/counter_bank.sv
// counter_bank: shared prescaler tick plus N_CH host-controlled counters
// with clear/load/step/auto-increment and one-cycle event pulses.
module counter_bank #(
  parameter int N_CH = 4,
  parameter int WIDTH = 8,
  parameter int DIV_WIDTH = 24,
  parameter int unsigned DIV_RELOAD = 32'h400000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         ch_clear,
  input  logic [N_CH-1:0]         ch_auto,
  input  logic [N_CH-1:0]         ch_sat,
  input  logic [N_CH-1:0]         up_pulse,
  input  logic [N_CH-1:0]         down_pulse,
  input  logic [N_CH-1:0]         load,
  input  logic [N_CH*WIDTH-1:0]   load_value,
  input  logic [N_CH*WIDTH-1:0]   cmp_value,
  output logic [N_CH*WIDTH-1:0]   count,
  output logic                    tick,
  output logic [N_CH-1:0]         zero_pulse,
  output logic [N_CH-1:0]         cmp_pulse,
  output logic [N_CH-1:0]         limit_pulse
);

  localparam logic [DIV_WIDTH-1:0] RELOAD = DIV_WIDTH'(DIV_RELOAD);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [DIV_WIDTH-1:0] div;

  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= RELOAD;
      tick <= 1'b0;
    end else if (div == '0) begin
      div  <= RELOAD;
      tick <= 1'b1;
    end else begin
      div  <= div - 1'b1;
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] nxt;
    logic             z_q;
    logic             c_q;
    logic             l_q;
    logic             inc;
    logic             dec;
    logic             wr;
    logic             lim;

    // auto-increment shares the up path; any pulse masks the tick
    assign inc = up_pulse[i] |
                 (~down_pulse[i] & ch_auto[i] & tick);
    assign dec = ~up_pulse[i] & down_pulse[i];

    always_comb begin
      nxt = cnt_q;
      wr  = 1'b0;
      lim = 1'b0;
      if (ch_clear[i]) begin
        nxt = '0;
      end else if (load[i]) begin
        nxt = load_value[i*WIDTH +: WIDTH];
        wr  = 1'b1;
      end else if (inc) begin
        wr = 1'b1;
        if (cnt_q == MAX) begin
          lim = 1'b1;
          nxt = ch_sat[i] ? MAX : '0;
        end else begin
          nxt = cnt_q + 1'b1;
        end
      end else if (dec) begin
        wr = 1'b1;
        if (cnt_q == '0) begin
          lim = 1'b1;
          nxt = ch_sat[i] ? '0 : MAX;
        end else begin
          nxt = cnt_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        z_q   <= 1'b0;
        c_q   <= 1'b0;
        l_q   <= 1'b0;
      end else begin
        cnt_q <= nxt;
        z_q   <= (nxt == '0) && (cnt_q != '0);
        c_q   <= wr && (nxt == cmp_value[i*WIDTH +: WIDTH]);
        l_q   <= lim;
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign zero_pulse[i]  = z_q;
    assign cmp_pulse[i]   = c_q;
    assign limit_pulse[i] = l_q;
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed + random stimulus against an
// integer-arithmetic reference model of the counter bank.
module tb_counter_bank;

  localparam int NC = 4;
  localparam int W = 8;
  localparam int DR = 3;
  localparam int MAXV = 255;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0] ch_clear, ch_auto, ch_sat;
  logic [NC-1:0] up_pulse, down_pulse, load;
  logic [NC*W-1:0] load_value, cmp_value;
  logic [NC*W-1:0] count;
  logic tick;
  logic [NC-1:0] zero_pulse, cmp_pulse, limit_pulse;

  counter_bank #(
    .N_CH(NC), .WIDTH(W), .DIV_WIDTH(24), .DIV_RELOAD(DR)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_clear(ch_clear), .ch_auto(ch_auto), .ch_sat(ch_sat),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .load(load),
    .load_value(load_value), .cmp_value(cmp_value),
    .count(count), .tick(tick),
    .zero_pulse(zero_pulse), .cmp_pulse(cmp_pulse),
    .limit_pulse(limit_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  int m_cnt[NC];
  bit m_z[NC], m_c[NC], m_l[NC];
  bit m_tick;
  int edges;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int c, n, lv;
    bit stepped, lim;
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = 0; m_z[i] = 0; m_c[i] = 0; m_l[i] = 0;
      end
      edges = 0;
      m_tick = 0;
      return;
    end
    for (int i = 0; i < NC; i++) begin
      c = m_cnt[i];
      n = c;
      stepped = 0;
      lim = 0;
      lv = int'(load_value[i*W +: W]);
      if (ch_clear[i]) n = 0;
      else if (load[i]) begin
        n = lv; stepped = 1;
      end else if (up_pulse[i] || (!down_pulse[i] && ch_auto[i] && m_tick)) begin
        stepped = 1;
        n = c + 1;
        if (n > MAXV) begin lim = 1; n = ch_sat[i] ? MAXV : 0; end
      end else if (down_pulse[i]) begin
        stepped = 1;
        n = c - 1;
        if (n < 0) begin lim = 1; n = ch_sat[i] ? 0 : MAXV; end
      end
      m_z[i] = (n == 0) && (c != 0);
      m_c[i] = stepped && (n == int'(cmp_value[i*W +: W]));
      m_l[i] = lim;
      m_cnt[i] = n;
    end
    edges++;
    m_tick = (edges % (DR + 1)) == 0;
  endtask

  task automatic compare();
    check("tick", 32'(tick), 32'(m_tick));
    for (int i = 0; i < NC; i++) begin
      check($sformatf("cnt%0d", i), 32'(count[i*W +: W]), 32'(m_cnt[i]));
      check($sformatf("zero%0d", i), 32'(zero_pulse[i]), 32'(m_z[i]));
      check($sformatf("cmp%0d", i), 32'(cmp_pulse[i]), 32'(m_c[i]));
      check($sformatf("lim%0d", i), 32'(limit_pulse[i]), 32'(m_l[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic idle_pulses();
    ch_clear = '0; up_pulse = '0; down_pulse = '0; load = '0;
  endtask

  int guard;
  int ticks_seen;

  initial begin
    reset = 1'b1;
    idle_pulses();
    ch_auto = '0; ch_sat = '0;
    load_value = '0; cmp_value = '1;
    m_tick = 0; edges = 0;
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    // reset must override active controls
    load = '1; load_value = 32'hA5A5A5A5; up_pulse = '1;
    cyc(); cyc();
    idle_pulses();
    reset = 1'b0;

    // prescaler: tick on cycles 4, 8, 12 after release
    ticks_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k % 4 == 0) check("tick_at_k", 32'(tick), 32'd1);
      if (tick) ticks_seen++;
    end
    check("tick_count", ticks_seen, 3);

    // auto wrap on ch0 from FE
    load[0] = 1'b1; load_value[7:0] = 8'hFE; ch_auto[0] = 1'b1;
    cyc();
    idle_pulses();
    check("auto_load", 32'(count[7:0]), 32'hFE);
    guard = 0;
    while (count[7:0] != 8'h00 && guard < 20) begin
      cyc(); guard++;
    end
    check("auto_wrap_bound", 32'(guard < 20), 32'd1);
    check("auto_wrap_lim", 32'(limit_pulse[0]), 32'd1);
    check("auto_wrap_zero", 32'(zero_pulse[0]), 32'd1);
    ch_auto[0] = 1'b0;

    // saturate on ch1
    ch_sat[1] = 1'b1;
    load[1] = 1'b1; load_value[15:8] = 8'hFF;
    cyc();
    idle_pulses();
    for (int k = 0; k < 3; k++) begin
      up_pulse[1] = 1'b1;
      cyc();
      check("sat_hi", 32'(count[15:8]), 32'hFF);
      check("sat_hi_lim", 32'(limit_pulse[1]), 32'd1);
    end
    idle_pulses();
    load[1] = 1'b1; load_value[15:8] = 8'h00;
    cyc();
    idle_pulses();
    down_pulse[1] = 1'b1;
    cyc();
    idle_pulses();
    check("sat_lo", 32'(count[15:8]), 32'h00);
    check("sat_lo_lim", 32'(limit_pulse[1]), 32'd1);
    ch_sat[1] = 1'b0;

    // priority on ch2, aligned so tick is high at the sampling edge
    guard = 0;
    while (!tick && guard < 10) begin
      cyc(); guard++;
    end
    check("tick_wait", 32'(tick), 32'd1);
    ch_auto[2] = 1'b1;
    load[2] = 1'b1; load_value[23:16] = 8'h10; up_pulse[2] = 1'b1;
    cyc();
    idle_pulses();
    ch_auto[2] = 1'b0;
    check("prio_load", 32'(count[23:16]), 32'h10);
    up_pulse[2] = 1'b1; down_pulse[2] = 1'b1;
    cyc();
    idle_pulses();
    check("prio_updn", 32'(count[23:16]), 32'h11);
    ch_clear[2] = 1'b1; load[2] = 1'b1;
    cyc();
    idle_pulses();
    check("prio_clr", 32'(count[23:16]), 32'h00);

    // compare on ch3
    cmp_value[31:24] = 8'h05;
    load[3] = 1'b1; load_value[31:24] = 8'h03;
    cyc();
    idle_pulses();
    for (int k = 0; k < 3; k++) begin
      up_pulse[3] = 1'b1;
      cyc();
      check("cmp_step", 32'(cmp_pulse[3]), 32'(count[31:24] == 8'h05 && k == 1));
    end
    idle_pulses();
    load[3] = 1'b1; load_value[31:24] = 8'h05;
    cyc();
    idle_pulses();
    check("cmp_load", 32'(cmp_pulse[3]), 32'd1);
    ch_clear[3] = 1'b1;
    cyc();
    check("cmp_clr", 32'(cmp_pulse[3]), 32'd0);
    cyc();
    check("clr_held_zero", 32'(zero_pulse[3]), 32'd0);
    idle_pulses();
    load[3] = 1'b1;
    cyc();
    idle_pulses();
    check("cmp_reload", 32'(cmp_pulse[3]), 32'd1);

    // random traffic on all channels
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NC; i++) begin
        ch_clear[i]   = ($urandom_range(15) == 0);
        load[i]       = ($urandom_range(7) == 0);
        up_pulse[i]   = ($urandom_range(3) == 0);
        down_pulse[i] = ($urandom_range(3) == 0);
        if ($urandom_range(15) == 0) ch_auto[i] = ~ch_auto[i];
        if ($urandom_range(15) == 0) ch_sat[i] = ~ch_sat[i];
        load_value[i*W +: W] = ($urandom_range(1) == 0) ?
          8'($urandom_range(3)) : 8'($urandom_range(255) | 8'hFC);
        cmp_value[i*W +: W] = 8'($urandom_range(5));
      end
      cyc();
    end

    // reset mid-run
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    idle_pulses();
    check("rst_cnt", count, 32'd0);
    check("rst_pulses", {20'd0, zero_pulse, cmp_pulse, limit_pulse}, 32'd0);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised multi-channel counter block for host-controlled FPGA sample designs. A shared prescaler generates a periodic tick. Each of `N_CH` independent counters can be cleared, loaded, stepped up or down by host trigger pulses, or auto-incremented on the tick. Each channel reports its count plus one-cycle event pulses (zero, compare match, limit), sized to feed wire-out and trigger-out endpoints directly.

## Interface
- `N_CH`, 4: number of counter channels (1..16).
- `WIDTH`, 8: counter width in bits (2..32).
- `DIV_WIDTH`, 24: prescaler register width.
- `DIV_RELOAD`, 24'h400000: prescaler reload value; tick period is `DIV_RELOAD+1` cycles. Must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `ch_clear`  in  N_CH  per-channel level clear.
- `ch_auto`  in  N_CH  per-channel enable for tick-driven increment.
- `ch_sat`  in  N_CH  per-channel limit mode: 1 = saturate, 0 = wrap.
- `up_pulse`  in  N_CH  single-cycle step-up request.
- `down_pulse`  in  N_CH  single-cycle step-down request.
- `load`  in  N_CH  single-cycle load request.
- `load_value`  in  N_CH*WIDTH  load data; channel i is at `[i*WIDTH +: WIDTH]`.
- `cmp_value`  in  N_CH*WIDTH  compare value per channel, using the same packing as `load_value`.
- `count`  out  N_CH*WIDTH  registered count values, using the same packing.
- `tick`  out  1  prescaler tick, high for one cycle.
- `zero_pulse`  out  N_CH  count became 0 from a nonzero value.
- `cmp_pulse`  out  N_CH  an update wrote a value equal to `cmp_value`.
- `limit_pulse`  out  N_CH  a step crossed the range limit (wrapped or was clamped).

## Operation
- Prescaler `div` is a `DIV_WIDTH`-bit down-counter.
  - When `div == 0`: `div <= DIV_RELOAD` and `tick <= 1`.
  - Otherwise: `div <= div - 1` and `tick <= 0`.
- Per-channel update on each edge, in strict priority order. Exactly one action is taken.
  1. `ch_clear`: count ← 0.
  2. `load`: count ← `load_value`.
  3. `up_pulse`: step +1.
  4. `down_pulse`: step −1.
  5. `ch_auto && tick`: step +1.
  6. Otherwise: hold.
- Simultaneous `up_pulse` and `down_pulse`: up wins and down is dropped. A tick coincident with any higher-priority action is dropped, not deferred.
- Step arithmetic is modulo 2^WIDTH.
  - Up from `{WIDTH{1}}`, wrap mode: result 0, `limit_pulse` asserted.
  - Up from `{WIDTH{1}}`, saturate mode: result holds at max, `limit_pulse` asserted.
  - Down from 0: symmetric (wrap mode gives max; saturate mode holds at 0). `limit_pulse` asserted in both modes.
- `zero_pulse`: the next count is 0 and the current count is nonzero. This covers any source, including clear and load.
- `cmp_pulse`: a step or load writes a value equal to `cmp_value` sampled on the same edge. Clear never raises it. A saturated hold that equals `cmp_value` does raise it, because a step occurred.
- Channels are fully independent. They share only `tick`.

## Timing
- Reset values:
  - `count` = 0 and all pulse outputs = 0.
  - `tick` = 0 and `div` = `DIV_RELOAD`.
- Reset overrides every input on the same edge. Reset asserted mid-count zeroes all channels on the next edge.
- After reset release, the first `tick` is high in the cycle following edge `DIV_RELOAD+1`. Subsequent ticks repeat every `DIV_RELOAD+1` cycles.
- Control inputs are sampled on edge E. The new `count` and its pulses become visible after E, in the same cycle. Control-to-count latency is 1 cycle.
- An auto increment lands one cycle after the cycle in which `tick` is high.
- Every pulse output is high for exactly one cycle per event. A level-held `ch_clear` yields one `zero_pulse` only, because the count is already 0 on later cycles.
- Back-to-back `up_pulse` on consecutive cycles produces one step per cycle, with no lost steps.

## Test plan
- Reset and prescaler, `DIV_RELOAD=3`: release reset, then monitor `tick`. Required: `count` = 0, `tick` high on cycles 4, 8, 12.
- Auto count, wrap, `WIDTH=8`: `load` 8'hFE with `ch_auto=1`, then run 2 ticks. Required: count goes FF → 00, with `limit_pulse` and `zero_pulse` both asserted on the 00 cycle.
- Saturate: `ch_sat=1` at count 8'hFF, apply 3 `up_pulse`. Required: count stays FF and `limit_pulse` asserts 3 times. Then at count 0 apply one `down_pulse`. Required: count stays 0 and `limit_pulse` is asserted.
- Priority, all in the same cycle:
  - Assert `load` (8'h10), `up_pulse`, and `tick` with `ch_auto=1`. Required: count = 10.
  - Assert `up_pulse` and `down_pulse` together. Required: count = 11.
  - Assert `ch_clear` and `load`. Required: count = 0.
- Compare: set `cmp_value` = 8'h05, then up-step from 3. Required: `cmp_pulse` exactly once, on the cycle count = 5. A clear at 5 followed by a load of 5 raises `cmp_pulse` only for the load.
- Channel independence and reset mid-run, `N_CH=4`: run distinct patterns on all channels, then assert `reset` for 1 cycle. Required: no cross-channel effects before reset; all counts 0 and no pulses on the next cycle.
